// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter that sequences single accesses on an async-read,
// write-strobe RAM port (setup / strobe / hold), returning a one-cycle ack per access.
module mem_bus_arbiter #(
  parameter int                 DATA_W    = 8,
  parameter int                 MEM_BASE  = 0,
  parameter int                 MEM_SIZE  = 60000,
  parameter logic [DATA_W-1:0]  OOR_RDATA = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [2*DATA_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [2*DATA_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [2*DATA_W-1:0]   mem_addr,
  output logic                  mem_r_w,
  output logic                  mem_write,
  inout  wire  [DATA_W-1:0]     mem_data,
  output logic                  busy,
  output logic                  grant
);
  localparam int AW = 2*DATA_W;
  localparam logic [AW:0] LO = (AW+1)'(MEM_BASE);
  localparam logic [AW:0] HI = (AW+1)'(MEM_BASE + MEM_SIZE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic                   gnt_q, gnt_d;
  logic                   rr_q, rr_d;
  logic                   we_q, we_d;
  logic                   oor_q, oor_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   r_w_q, r_w_d;
  logic                   write_q, write_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic [1:0]             ack_q, ack_d;
  logic [1:0]             err_q, err_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic                   win;
  logic                   sel_we, sel_oor;
  logic [AW-1:0]          sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  // Single requester always wins; on a tie the round-robin pointer decides.
  always_comb begin
    win       = (m0_req && m1_req) ? rr_q : m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_oor   = ({1'b0, sel_addr} < LO) || ({1'b0, sel_addr} >= HI);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    we_d    = we_q;
    oor_d   = oor_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    r_w_d   = r_w_q;
    write_d = 1'b0;
    oe_d    = oe_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = S_SETUP;
          gnt_d   = win;
          we_d    = sel_we;
          oor_d   = sel_oor;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // Out-of-range accesses never turn the RAM bus around.
          r_w_d   = sel_we || sel_oor;
          oe_d    = sel_we && !sel_oor;
        end
      end
      S_SETUP: begin
        if (we_q && !oor_q) begin
          state_d = S_STROBE;
          write_d = 1'b1;
        end else begin
          state_d       = S_DONE;
          r_w_d         = 1'b1;
          oe_d          = 1'b0;
          ack_d[gnt_q]  = 1'b1;
          err_d[gnt_q]  = oor_q;
          if (!we_q)
            rdata_d[gnt_q] = oor_q ? OOR_RDATA : mem_data;
        end
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        state_d      = S_DONE;
        r_w_d        = 1'b1;
        oe_d         = 1'b0;
        ack_d[gnt_q] = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = ~gnt_q;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      r_w_q   <= 1'b1;
      write_q <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      r_w_q   <= r_w_d;
      write_q <= write_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_data  = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign mem_addr  = addr_q;
  assign mem_r_w   = r_w_q;
  assign mem_write = write_q;
  assign busy      = busy_q;
  assign grant     = gnt_q;
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: RAM model on the bus, scoreboard of expected acks,
// per-cycle bus-protocol checks.
`define CHK(TAG, OBS, EXP) begin total++; assert ((OBS) === (EXP)) else begin bad++; $error("FAIL %s: got %0h want %0h", TAG, OBS, EXP); end end

module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [7:0]  m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err, mem_r_w, mem_write, busy, grant;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         m;
    bit         we;
    bit         err;
    logic [7:0] rd;
  } sb_t;
  sb_t sb[$];

  logic [7:0] ram [0:65535];
  logic [7:0] mdl [0:65535];
  logic [7:0] exp_rd [2];
  int         wr_cycles;
  bit         saw_write, saw_rd;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_r_w(mem_r_w), .mem_write(mem_write),
    .mem_data(mem_data), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // Async-read RAM: drives the bus only while mem_r_w is low.
  assign mem_data = !mem_r_w ? ram[mem_addr] : 8'bzzzzzzzz;
  always @(posedge mem_write) ram[mem_addr] = mem_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ack || m1_ack) begin
        `CHK("single_ack", m0_ack & m1_ack, 1'b0)
        if (sb.size() == 0) begin
          total++; bad++;
          $error("FAIL unexpected_ack: got ack with empty scoreboard, want none");
        end else begin
          sb_t e;
          e = sb.pop_front();
          `CHK("ack_master", m1_ack, e.m)
          `CHK("ack_err", (e.m ? m1_err : m0_err), e.err)
          if (!e.we) exp_rd[e.m] = e.rd;
        end
      end else begin
        `CHK("err_without_ack", m0_err | m1_err, 1'b0)
      end
      `CHK("m0_rdata", m0_rdata, exp_rd[0])
      `CHK("m1_rdata", m1_rdata, exp_rd[1])
      if (!mem_r_w) begin
        `CHK("no_strobe_in_read", mem_write, 1'b0)
        `CHK("read_bus_value", mem_data, ram[mem_addr])
        saw_rd = 1'b1;
      end
      if (mem_write) begin
        wr_cycles++;
        saw_write = 1'b1;
      end
    end
  end

  task automatic start(input bit m, input bit we, input logic [15:0] a, input logic [7:0] d);
    sb_t e;
    e.m   = m;
    e.we  = we;
    e.err = (a >= 16'd60000);
    e.rd  = e.err ? 8'hFF : mdl[a];
    if (we && !e.err) mdl[a] = d;
    sb.push_back(e);
    if (m) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic wait_ack(input bit m, input int lat, input string tag);
    int n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (m ? m1_ack : m0_ack) begin n = i; break; end
    end
    `CHK(tag, n, lat)
    if (n != 0) `CHK("ack_grant", grant, m)
    if (m) m1_req = 0; else m0_req = 0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe();
    int n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mem_write) begin n = i; break; end
    end
    `CHK("strobe_seen", n != 0, 1'b1)
  endtask

  initial begin
    int   k;
    logic exp_g;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'(i) ^ 8'h5A;
      mdl[i] = 8'(i) ^ 8'h5A;
    end
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_mem_write", mem_write, 1'b0)
    `CHK("rst_mem_r_w", mem_r_w, 1'b1)
    `CHK("rst_mem_addr", mem_addr, 16'h0000)
    `CHK("rst_grant", grant, 1'b0)
    `CHK("rst_acks", {m0_ack, m1_ack}, 2'b00)

    // Simultaneous requests after reset: M0 first, then alternating
    start(0, 0, 16'h0100, 8'h00);
    start(1, 0, 16'h0200, 8'h00);
    start(0, 0, 16'h0100, 8'h00);
    start(1, 0, 16'h0200, 8'h00);
    k = 0;
    exp_g = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack) begin
        `CHK("rr_grant", grant, exp_g)
        exp_g = ~exp_g;
        k++;
        if (k == 4) begin m0_req = 0; m1_req = 0; break; end
      end
    end
    `CHK("rr_ack_count", k, 4)
    idle();

    // M0 write then read back
    wr_cycles = 0;
    start(0, 1, 16'h0010, 8'hA5);
    wait_ack(0, 4, "write_latency");
    `CHK("strobe_width", wr_cycles, 1)
    idle();
    start(0, 0, 16'h0010, 8'h00);
    wait_ack(0, 2, "read_latency");
    idle();

    // M1 out-of-range read: no RAM cycle at all
    saw_write = 0;
    saw_rd    = 0;
    start(1, 0, 16'hFFF0, 8'h00);
    wait_ack(1, 2, "oor_latency");
    `CHK("oor_no_strobe", saw_write, 1'b0)
    `CHK("oor_no_read_turn", saw_rd, 1'b0)
    idle();

    // Inputs changed mid-write are ignored
    start(0, 1, 16'h0020, 8'h3C);
    wait_strobe();
    m0_addr  = 16'h0021;
    m0_wdata = 8'hC3;
    wait_ack(0, 2, "latched_write_latency");
    `CHK("latched_write_data", ram[16'h0020], 8'h3C)
    `CHK("latched_write_other", ram[16'h0021], 8'h21 ^ 8'h5A)
    idle();
    start(0, 0, 16'h0020, 8'h00);
    wait_ack(0, 2, "latched_read_latency");
    idle();

    // Reset during STROBE; pointer currently favours M1
    start(0, 1, 16'h0030, 8'h77);
    wait_strobe();
    rst    = 1;
    m0_req = 0;
    void'(sb.pop_back());
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    @(posedge clk); #1;
    `CHK("abort_mem_write", mem_write, 1'b0)
    `CHK("abort_busy", busy, 1'b0)
    `CHK("abort_mem_r_w", mem_r_w, 1'b1)
    `CHK("abort_no_ack", m0_ack, 1'b0)
    `CHK("abort_grant", grant, 1'b0)
    `CHK("abort_rdata", m0_rdata, 8'h00)
    rst = 0;
    start(0, 0, 16'h0010, 8'h00);
    start(1, 0, 16'h0200, 8'h00);
    wait_ack(0, 2, "post_rst_m0_first");
    wait_ack(1, 3, "post_rst_m1_next");
    repeat (3) idle();
    `CHK("scoreboard_empty", sb.size(), 0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
